id_alu_issue: RTL

- Decode/issue stage for the TaoShuRV integer pipeline; the producer side of the ALU control/operand interface.
- Accepts a fetched RV32I instruction and its PC from IF over a valid/ready handshake.
- Reads the register file, builds the immediate, and encodes alu_ctrl, alu_src1 and alu_src2.
- Holds the decoded bundle in a handshaked pipeline register for EX, with flush support.

---
 rtl/id_alu_issue_pkg.sv | 52 +++++
 rtl/id_alu_issue_imm_gen.sv | 27 ++
 rtl/id_alu_issue.sv | 193 +++++++++++++++++++
 3 files changed

// File: rtl/id_alu_issue_pkg.sv
// ----------------------------------------------------------------------------
// id_alu_issue_pkg
// Shared constants for the TaoShuRV decode/issue stage: ALU operation codes
// and the RV32I major opcodes handled by the integer ALU path.
// No ports (package).
// ----------------------------------------------------------------------------
package id_alu_issue_pkg;

    localparam int XLEN_DEF = 32;

    typedef enum logic [3:0] {
        ALU_OP_ADD  = 4'd0,
        ALU_OP_SUB  = 4'd1,
        ALU_OP_SLT  = 4'd2,
        ALU_OP_SLTU = 4'd3,
        ALU_OP_AND  = 4'd4,
        ALU_OP_OR   = 4'd5,
        ALU_OP_XOR  = 4'd6,
        ALU_OP_SLL  = 4'd7,
        ALU_OP_SRL  = 4'd8,
        ALU_OP_SRA  = 4'd9,
        ALU_OP_LUI  = 4'd10
    } alu_op_e;

    localparam logic [6:0] OPC_OP     = 7'b0110011;
    localparam logic [6:0] OPC_OP_IMM = 7'b0010011;
    localparam logic [6:0] OPC_LUI    = 7'b0110111;
    localparam logic [6:0] OPC_AUIPC  = 7'b0010111;
    localparam logic [6:0] OPC_LOAD   = 7'b0000011;
    localparam logic [6:0] OPC_STORE  = 7'b0100011;

    localparam logic [6:0] FUNCT7_BASE = 7'b0000000;
    localparam logic [6:0] FUNCT7_ALT  = 7'b0100000;

    // Register-form funct3 to ALU code for funct7 = 0000000; also valid for
    // the non-shift immediate forms (funct3 001/101 handled by the caller).
    function automatic alu_op_e funct3_to_op(input logic [2:0] funct3);
        alu_op_e op;
        case (funct3)
            3'b000:  op = ALU_OP_ADD;
            3'b001:  op = ALU_OP_SLL;
            3'b010:  op = ALU_OP_SLT;
            3'b011:  op = ALU_OP_SLTU;
            3'b100:  op = ALU_OP_XOR;
            3'b101:  op = ALU_OP_SRL;
            3'b110:  op = ALU_OP_OR;
            default: op = ALU_OP_AND;
        endcase
        return op;
    endfunction

endpackage

// File: rtl/id_alu_issue_imm_gen.sv
// ----------------------------------------------------------------------------
// id_alu_issue_imm_gen
// Combinational immediate builder for RV32I.
// Ports:
//   inst_hi  in   inst[31:7] (opcode bits are not needed here)
//   imm_i    out  sign-extended I-type immediate
//   imm_s    out  sign-extended S-type immediate
//   imm_u    out  U-type immediate {inst[31:12], 12'b0}
//   shamt    out  zero-extended shift amount inst[24:20]
// ----------------------------------------------------------------------------
module id_alu_issue_imm_gen #(
    parameter int XLEN = 32
) (
    input  logic [31:7]     inst_hi,
    output logic [XLEN-1:0] imm_i,
    output logic [XLEN-1:0] imm_s,
    output logic [XLEN-1:0] imm_u,
    output logic [XLEN-1:0] shamt
);

    assign imm_i = {{(XLEN-12){inst_hi[31]}}, inst_hi[31:20]};
    assign imm_s = {{(XLEN-12){inst_hi[31]}}, inst_hi[31:25], inst_hi[11:7]};
    // Written as sign bit + [30:12] so the replication stays non-zero at XLEN=32.
    assign imm_u = {{(XLEN-31){inst_hi[31]}}, inst_hi[30:12], 12'b0};
    assign shamt = {{(XLEN-5){1'b0}}, inst_hi[24:20]};

endmodule

// File: rtl/id_alu_issue.sv
// ----------------------------------------------------------------------------
// id_alu_issue
// RV32I decode/issue stage: takes an IF bundle over valid/ready, reads the
// register file, decodes ALU control and operands, and holds the result in a
// handshaked pipeline register for EX. Flush kills both the held bundle and
// anything accepted in the same cycle.
// Ports:
//   clk, rst_n                      clock, async active-low reset
//   flush                           kill held/incoming bundle
//   in_valid/in_ready               IF handshake
//   in_inst, in_pc                  instruction word and PC
//   rs1_addr, rs2_addr              regfile read addresses (combinational)
//   rs1_data, rs2_data              regfile read data (same cycle)
//   out_valid/out_ready             EX handshake
//   out_alu_ctrl, out_alu_src1/2    ALU code and operands
//   out_rd_addr, out_rd_wen         destination and write enable
//   out_illegal                     unsupported opcode/funct
//   out_pc                          PC of the held bundle
// ----------------------------------------------------------------------------
module id_alu_issue
    import id_alu_issue_pkg::*;
#(
    parameter int XLEN = 32
) (
    input  logic            clk,
    input  logic            rst_n,
    input  logic            flush,
    input  logic            in_valid,
    output logic            in_ready,
    input  logic [31:0]     in_inst,
    input  logic [XLEN-1:0] in_pc,
    output logic [4:0]      rs1_addr,
    output logic [4:0]      rs2_addr,
    input  logic [XLEN-1:0] rs1_data,
    input  logic [XLEN-1:0] rs2_data,
    output logic            out_valid,
    input  logic            out_ready,
    output logic [3:0]      out_alu_ctrl,
    output logic [XLEN-1:0] out_alu_src1,
    output logic [XLEN-1:0] out_alu_src2,
    output logic [4:0]      out_rd_addr,
    output logic            out_rd_wen,
    output logic            out_illegal,
    output logic [XLEN-1:0] out_pc
);

    logic [6:0]      opcode;
    logic [2:0]      funct3;
    logic [6:0]      funct7;
    logic [4:0]      rd_addr;
    logic [XLEN-1:0] rs1_val;
    logic [XLEN-1:0] rs2_val;
    logic [XLEN-1:0] imm_i;
    logic [XLEN-1:0] imm_s;
    logic [XLEN-1:0] imm_u;
    logic [XLEN-1:0] shamt;

    alu_op_e         dec_ctrl;
    logic [XLEN-1:0] dec_src1;
    logic [XLEN-1:0] dec_src2;
    logic            dec_illegal;
    logic            dec_wb;
    logic            dec_wen;
    logic            load;

    assign opcode   = in_inst[6:0];
    assign rd_addr  = in_inst[11:7];
    assign funct3   = in_inst[14:12];
    assign rs1_addr = in_inst[19:15];
    assign rs2_addr = in_inst[24:20];
    assign funct7   = in_inst[31:25];

    // x0 always reads as zero, whatever the regfile returns.
    assign rs1_val = (rs1_addr == 5'd0) ? '0 : rs1_data;
    assign rs2_val = (rs2_addr == 5'd0) ? '0 : rs2_data;

    id_alu_issue_imm_gen #(.XLEN(XLEN)) u_imm_gen (
        .inst_hi (in_inst[31:7]),
        .imm_i   (imm_i),
        .imm_s   (imm_s),
        .imm_u   (imm_u),
        .shamt   (shamt)
    );

    always_comb begin
        dec_ctrl    = ALU_OP_ADD;
        dec_src1    = '0;
        dec_src2    = '0;
        dec_illegal = 1'b0;
        dec_wb      = 1'b0;

        case (opcode)
            OPC_OP: begin
                dec_src1 = rs1_val;
                dec_src2 = rs2_val;
                dec_wb   = 1'b1;
                if (funct7 == FUNCT7_BASE) begin
                    dec_ctrl = funct3_to_op(funct3);
                end else if (funct7 == FUNCT7_ALT && funct3 == 3'b000) begin
                    dec_ctrl = ALU_OP_SUB;
                end else if (funct7 == FUNCT7_ALT && funct3 == 3'b101) begin
                    dec_ctrl = ALU_OP_SRA;
                end else begin
                    dec_illegal = 1'b1;
                end
            end
            OPC_OP_IMM: begin
                dec_src1 = rs1_val;
                dec_src2 = imm_i;
                dec_wb   = 1'b1;
                dec_ctrl = funct3_to_op(funct3);
                if (funct3 == 3'b001 || funct3 == 3'b101) begin
                    // Shift-immediate: upper imm bits are funct7, operand is shamt.
                    dec_src2 = shamt;
                    if (funct3 == 3'b101 && in_inst[30]) begin
                        dec_ctrl = ALU_OP_SRA;
                    end
                    if (funct7 != FUNCT7_BASE && funct7 != FUNCT7_ALT) begin
                        dec_illegal = 1'b1;
                    end
                end
            end
            OPC_LUI: begin
                dec_ctrl = ALU_OP_LUI;
                dec_src2 = imm_u;
                dec_wb   = 1'b1;
            end
            OPC_AUIPC: begin
                dec_src1 = in_pc;
                dec_src2 = imm_u;
                dec_wb   = 1'b1;
            end
            OPC_LOAD: begin
                dec_src1 = rs1_val;
                dec_src2 = imm_i;
                dec_wb   = 1'b1;
            end
            OPC_STORE: begin
                dec_src1 = rs1_val;
                dec_src2 = imm_s;
            end
            default: begin
                dec_illegal = 1'b1;
            end
        endcase

        // Illegal bundles carry a neutral payload so EX sees no stale operands.
        if (dec_illegal) begin
            dec_ctrl = ALU_OP_ADD;
            dec_src1 = '0;
            dec_src2 = '0;
            dec_wb   = 1'b0;
        end
    end

    assign dec_wen  = dec_wb && (rd_addr != 5'd0);

    assign in_ready = ~out_valid | out_ready;
    assign load     = in_valid & in_ready & ~flush;

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            out_valid <= 1'b0;
        end else if (flush) begin
            out_valid <= 1'b0;
        end else if (load) begin
            out_valid <= 1'b1;
        end else if (out_ready) begin
            out_valid <= 1'b0;
        end
    end

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            out_alu_ctrl <= ALU_OP_ADD;
            out_alu_src1 <= '0;
            out_alu_src2 <= '0;
            out_rd_addr  <= '0;
            out_rd_wen   <= 1'b0;
            out_illegal  <= 1'b0;
            out_pc       <= '0;
        end else if (load) begin
            out_alu_ctrl <= dec_ctrl;
            out_alu_src1 <= dec_src1;
            out_alu_src2 <= dec_src2;
            out_rd_addr  <= rd_addr;
            out_rd_wen   <= dec_wen;
            out_illegal  <= dec_illegal;
            out_pc       <= in_pc;
        end
    end

endmodule
